// File: rtl/multicycle_executor_pkg.sv
// Shared definitions for the multi-cycle RV32I executor: FSM states,
// trap cause codes, major opcodes, load/store size codes (funct3) and the
// ALU operation set with its funct3/funct7 decoder.
package multicycle_executor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ILLEGAL  = 2'd1,
    CAUSE_MISALIGN = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } trap_cause_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  // alt selects SUB for funct3=000 and SRA for funct3=101.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_executor_regfile.sv
// Architectural register file with asynchronous clear.
// Ports: clk/reset; write port (we, waddr, wdata); two combinational read
// ports (raddr1/rdata1, raddr2/rdata2). x0 always reads zero and ignores
// writes; indices at or above NREGS read as zero (the executor traps them).
module regfile_async_reset #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      for (int i = 1; i < NREGS; i++)
        if (waddr == 5'(i)) regs[i] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (raddr1 == 5'(i)) rdata1 = regs[i];
      if (raddr2 == 5'(i)) rdata2 = regs[i];
    end
  end

endmodule

// File: rtl/multicycle_executor.sv
// Multi-cycle RV32I subset executor. One instruction at a time is accepted
// over instr_valid/instr_ready and runs IDLE -> EXEC -> [MEM] -> WB/TRAP.
// Ports: clk, reset (async, active-high); instr_valid/instr_ready,
// instruction, pc (issue side); done, next_pc, trap, trap_cause (retire
// side); bus_req, bus_we, bus_address, bus_wr_data, bus_size, bus_read_data,
// bus_ack (wait-state memory bus, request held until ack or timeout).
module multicycle_executor
  import multicycle_executor_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NREGS       = 32,
  parameter int BUS_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  output logic            done,
  output logic [XLEN-1:0] next_pc,
  output logic            trap,
  output logic [1:0]      trap_cause,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_address,
  output logic [XLEN-1:0] bus_wr_data,
  output logic [2:0]      bus_size,
  input  logic [XLEN-1:0] bus_read_data,
  input  logic            bus_ack
);

  localparam int SHW   = $clog2(XLEN);
  localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);

  state_e state, state_nxt;

  logic [31:0]      instr_p0;
  logic [XLEN-1:0]  pc_p0;
  logic [XLEN-1:0]  result_p1;
  logic             wb_en_p1;
  logic [CNT_W-1:0] wait_cnt;

  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [XLEN-1:0] rs1_val, rs2_val, pc_plus4, mem_addr;
  logic signed [XLEN-1:0] rs1_s, rs2_s;

  logic illegal, misalign, use_rd, use_rs1, use_rs2, is_mem, is_store;
  logic br_taken, alt, wait_expired;
  logic [XLEN-1:0] exec_result, exec_next_pc;
  trap_cause_e exec_cause;

  function automatic logic [XLEN-1:0] alu(input alu_op_e op,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s, b_s;
    logic [SHW-1:0] sh;
    logic [XLEN-1:0] r;
    a_s = a;
    b_s = b;
    sh  = b[SHW-1:0];
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << sh;
      ALU_SLT:  r = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> sh;
      ALU_SRA:  r = a_s >>> sh;
      ALU_OR:   r = a | b;
      default:  r = a & b;
    endcase
    return r;
  endfunction

  // Bus data arrives right-aligned; only the low byte/halfword is kept.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] size,
                                                  input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (size)
      SZ_B:    r = {{(XLEN-8){d[7]}}, d[7:0]};
      SZ_H:    r = {{(XLEN-16){d[15]}}, d[15:0]};
      SZ_BU:   r = {{(XLEN-8){1'b0}}, d[7:0]};
      SZ_HU:   r = {{(XLEN-16){1'b0}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic reg_ok(input logic [4:0] idx);
    return int'(idx) < NREGS;
  endfunction

  assign opcode = instr_p0[6:0];
  assign rd     = instr_p0[11:7];
  assign f3     = instr_p0[14:12];
  assign rs1    = instr_p0[19:15];
  assign rs2    = instr_p0[24:20];
  assign f7     = instr_p0[31:25];

  assign imm_i = {{(XLEN-12){instr_p0[31]}}, instr_p0[31:20]};
  assign imm_s = {{(XLEN-12){instr_p0[31]}}, instr_p0[31:25], instr_p0[11:7]};
  assign imm_b = {{(XLEN-13){instr_p0[31]}}, instr_p0[31], instr_p0[7],
                  instr_p0[30:25], instr_p0[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){instr_p0[31]}}, instr_p0[31], instr_p0[19:12],
                  instr_p0[20], instr_p0[30:21], 1'b0};
  assign imm_u = {{(XLEN-31){instr_p0[31]}}, instr_p0[30:12], 12'h000};

  assign rs1_s    = rs1_val;
  assign rs2_s    = rs2_val;
  assign pc_plus4 = pc_p0 + XLEN'(4);
  assign mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);

  assign wait_expired = (wait_cnt == CNT_W'(BUS_TIMEOUT - 1));

  regfile_async_reset #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     ((state == S_WB) && wb_en_p1),
    .waddr  (rd),
    .wdata  (result_p1),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  // Decode / ALU / branch evaluation, consumed during EXEC.
  always_comb begin
    illegal      = 1'b0;
    use_rd       = 1'b0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    is_mem       = 1'b0;
    is_store     = 1'b0;
    br_taken     = 1'b0;
    alt          = 1'b0;
    exec_result  = '0;
    exec_next_pc = pc_plus4;
    case (opcode)
      OPC_LUI: begin
        use_rd      = 1'b1;
        exec_result = imm_u;
      end
      OPC_JAL: begin
        use_rd       = 1'b1;
        exec_result  = pc_plus4;
        exec_next_pc = pc_p0 + imm_j;
      end
      OPC_OPIMM: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        alt     = (f3 == 3'b101) && f7[5];
        if (f3 == 3'b001 && f7 != 7'h00) illegal = 1'b1;
        if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) illegal = 1'b1;
        exec_result = alu(alu_decode(f3, alt), rs1_val, imm_i);
      end
      OPC_OP: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        alt     = f7[5];
        if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))))
          illegal = 1'b1;
        exec_result = alu(alu_decode(f3, alt), rs1_val, rs2_val);
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        case (f3)
          3'b000:  br_taken = (rs1_val == rs2_val);
          3'b001:  br_taken = (rs1_val != rs2_val);
          3'b100:  br_taken = (rs1_s < rs2_s);
          3'b101:  br_taken = (rs1_s >= rs2_s);
          3'b110:  br_taken = (rs1_val < rs2_val);
          3'b111:  br_taken = (rs1_val >= rs2_val);
          default: illegal  = 1'b1;
        endcase
        if (br_taken) exec_next_pc = pc_p0 + imm_b;
      end
      OPC_LOAD: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        is_mem  = 1'b1;
        if (!(f3 == SZ_B || f3 == SZ_H || f3 == SZ_W || f3 == SZ_BU || f3 == SZ_HU))
          illegal = 1'b1;
      end
      OPC_STORE: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        is_mem   = 1'b1;
        is_store = 1'b1;
        if (!(f3 == SZ_B || f3 == SZ_H || f3 == SZ_W)) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if ((use_rd && !reg_ok(rd)) || (use_rs1 && !reg_ok(rs1)) ||
        (use_rs2 && !reg_ok(rs2)))
      illegal = 1'b1;
    misalign = is_mem && ((f3[1:0] == 2'b01 && mem_addr[0]) ||
                          (f3[1:0] == 2'b10 && mem_addr[1:0] != 2'b00));
    if (illegal)       exec_cause = CAUSE_ILLEGAL;
    else if (misalign) exec_cause = CAUSE_MISALIGN;
    else               exec_cause = CAUSE_NONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    trap        = 1'b0;
    bus_req     = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (exec_cause != CAUSE_NONE) state_nxt = S_TRAP;
        else if (is_mem)              state_nxt = S_MEM;
        else                          state_nxt = S_WB;
      end
      S_MEM: begin
        bus_req = 1'b1;
        // Ack takes priority over an expiring wait counter.
        if (bus_ack)           state_nxt = S_WB;
        else if (wait_expired) state_nxt = S_TRAP;
      end
      S_WB: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_TRAP: begin
        done      = 1'b1;
        trap      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_p0    <= '0;
      pc_p0       <= '0;
      result_p1   <= '0;
      wb_en_p1    <= 1'b0;
      wait_cnt    <= '0;
      next_pc     <= '0;
      trap_cause  <= '0;
      bus_we      <= 1'b0;
      bus_address <= '0;
      bus_wr_data <= '0;
      bus_size    <= '0;
    end else begin
      case (state)
        // IDLE -> EXEC: capture the issued instruction
        S_IDLE: begin
          if (instr_valid) begin
            instr_p0 <= instruction;
            pc_p0    <= pc;
          end
        end
        // EXEC -> MEM/WB/TRAP: register result, next pc and bus request
        S_EXEC: begin
          result_p1  <= exec_result;
          wb_en_p1   <= use_rd && (rd != 5'd0) && (exec_cause == CAUSE_NONE);
          next_pc    <= (exec_cause == CAUSE_NONE) ? exec_next_pc : pc_plus4;
          trap_cause <= exec_cause;
          wait_cnt   <= '0;
          if (is_mem && exec_cause == CAUSE_NONE) begin
            bus_we      <= is_store;
            bus_address <= mem_addr;
            bus_wr_data <= rs2_val;
            bus_size    <= f3;
          end
        end
        // MEM -> WB/TRAP: latch load data or count a wait state
        S_MEM: begin
          if (bus_ack)           result_p1  <= load_extend(bus_size, bus_read_data);
          else if (wait_expired) trap_cause <= CAUSE_TIMEOUT;
          else                   wait_cnt   <= wait_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_executor.sv
module tb_multicycle_executor;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        done;
  logic [31:0] next_pc;
  logic        trap;
  logic [1:0]  trap_cause;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_address;
  logic [31:0] bus_wr_data;
  logic [2:0]  bus_size;
  logic [31:0] bus_read_data;
  logic        bus_ack;

  multicycle_executor #(.XLEN(32), .NREGS(32), .BUS_TIMEOUT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .pc            (pc),
    .done          (done),
    .next_pc       (next_pc),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_address   (bus_address),
    .bus_wr_data   (bus_wr_data),
    .bus_size      (bus_size),
    .bus_read_data (bus_read_data),
    .bus_ack       (bus_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations of the most recent instruction.
  int          r_lat, r_req;
  logic [31:0] r_np, r_addr, r_wdata;
  logic        r_trap, r_we;
  logic [1:0]  r_cause;
  logic [2:0]  r_size;
  logic        pulse_busy = 1'b0;
  logic [31:0] pulse_ins  = 32'h0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] np;
    logic        trp;
    logic [1:0]  cause;
    int          rd;
    logic [31:0] val;
    logic        chk;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(int op, int rd, int f3, int rs1, int imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(int f3, int rs1, int rs2, int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int f3, int rs1, int rs2, int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(int rd, int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction
  function automatic logic [31:0] enc_u(int rd, int imm);
    return {imm[19:0], rd[4:0], 7'h37};
  endfunction

  function automatic vec_t mkv(logic [31:0] ins, logic [31:0] ipc, logic [31:0] np,
                               logic trp, logic [1:0] cause, int rd,
                               logic [31:0] val, logic chk);
    vec_t v;
    v.ins = ins; v.pc = ipc; v.np = np; v.trp = trp; v.cause = cause;
    v.rd = rd; v.val = val; v.chk = chk;
    return v;
  endfunction

  // Issue one instruction, serve the bus (ack after ack_wait wait cycles,
  // never if negative) and record what retires.
  task automatic exec(input logic [31:0] ins, input logic [31:0] ipc,
                      input int ack_wait, input logic [31:0] rdata);
    bit fin = 0;
    @(negedge clk);
    check("ready_at_issue", 32'(instr_ready), 32'h1);
    instr_valid = 1'b1;
    instruction = ins;
    pc          = ipc;
    r_req = 0; r_lat = 0; r_np = 'x; r_trap = 1'bx; r_cause = 'x;
    r_addr = 'x; r_wdata = 'x; r_size = 'x; r_we = 1'bx;
    @(posedge clk);
    for (int cyc = 1; cyc <= 100 && !fin; cyc++) begin
      @(negedge clk);
      if (pulse_busy) begin
        instr_valid = 1'b1;
        instruction = pulse_ins;
        pc          = ipc + 32'h40;
      end else begin
        instr_valid = 1'b0;
      end
      bus_ack = 1'b0;
      if (bus_req) begin
        r_addr  = bus_address;
        r_wdata = bus_wr_data;
        r_size  = bus_size;
        r_we    = bus_we;
        if (ack_wait >= 0 && r_req == ack_wait) begin
          bus_ack       = 1'b1;
          bus_read_data = rdata;
        end
        r_req++;
      end
      if (done) begin
        fin         = 1;
        r_lat       = cyc;
        r_np        = next_pc;
        r_trap      = trap;
        r_cause     = trap_cause;
        instr_valid = 1'b0;
      end
    end
    bus_ack = 1'b0;
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within 100 cycles for instruction 0x%08h", ins);
    end
  endtask

  task automatic read_reg(input int idx, output logic [31:0] val);
    exec(enc_s(2, 0, idx, 0), 32'h800, 0, 32'h0);
    val = r_wdata;
  endtask

  initial begin
    logic [31:0] rv;
    int          ndone;

    reset = 1'b1; instr_valid = 1'b0; instruction = '0; pc = '0;
    bus_ack = 1'b0; bus_read_data = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(instr_ready), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    check("rst_trap", {31'b0, trap} | {30'b0, trap_cause}, 32'h0);
    check("rst_next_pc", next_pc, 32'h0);
    check("rst_bus", {28'b0, bus_req, bus_we, 2'b0} | bus_address | bus_wr_data | {29'b0, bus_size}, 32'h0);
    reset = 1'b0;

    // Non-memory instructions, each retiring 2 cycles after accept.
    vecs.push_back(mkv(32'hFFB00093,                 32'h100, 32'h104, 0, 0, 1,  32'hFFFFFFFB, 1));
    vecs.push_back(mkv(enc_i('h13, 2, 0, 0, 3),      32'h104, 32'h108, 0, 0, 2,  32'h3, 1));
    vecs.push_back(mkv(enc_b(4, 1, 2, 16),           32'h108, 32'h118, 0, 0, 16, 32'h0, 1));
    vecs.push_back(mkv(enc_b(6, 1, 2, 16),           32'h10C, 32'h110, 0, 0, 16, 32'h0, 1));
    vecs.push_back(mkv(enc_r('h20, 1, 2, 0, 4),      32'h110, 32'h114, 0, 0, 4,  32'h8, 1));
    vecs.push_back(mkv(enc_r(0, 2, 1, 0, 20),        32'h114, 32'h118, 0, 0, 20, 32'hFFFFFFFE, 1));
    vecs.push_back(mkv(enc_r(0, 2, 1, 2, 5),         32'h118, 32'h11C, 0, 0, 5,  32'h1, 1));
    vecs.push_back(mkv(enc_r(0, 2, 1, 3, 6),         32'h11C, 32'h120, 0, 0, 6,  32'h0, 1));
    vecs.push_back(mkv(enc_i('h13, 7, 5, 1, 'h401),  32'h120, 32'h124, 0, 0, 7,  32'hFFFFFFFD, 1));
    vecs.push_back(mkv(enc_i('h13, 8, 5, 1, 4),      32'h124, 32'h128, 0, 0, 8,  32'h0FFFFFFF, 1));
    vecs.push_back(mkv(enc_i('h13, 11, 0, 0, 33),    32'h128, 32'h12C, 0, 0, 11, 32'h21, 1));
    vecs.push_back(mkv(enc_r(0, 11, 2, 1, 10),       32'h12C, 32'h130, 0, 0, 10, 32'h6, 1));
    vecs.push_back(mkv(enc_r('h20, 11, 1, 5, 21),    32'h130, 32'h134, 0, 0, 21, 32'hFFFFFFFD, 1));
    vecs.push_back(mkv(enc_r(0, 11, 1, 5, 22),       32'h134, 32'h138, 0, 0, 22, 32'h7FFFFFFD, 1));
    vecs.push_back(mkv(enc_i('h13, 12, 4, 1, -1),    32'h138, 32'h13C, 0, 0, 12, 32'h4, 1));
    vecs.push_back(mkv(enc_i('h13, 13, 6, 2, 'h70),  32'h13C, 32'h140, 0, 0, 13, 32'h73, 1));
    vecs.push_back(mkv(enc_i('h13, 14, 7, 1, 'hF0),  32'h140, 32'h144, 0, 0, 14, 32'hF0, 1));
    vecs.push_back(mkv(enc_i('h13, 23, 2, 1, -6),    32'h144, 32'h148, 0, 0, 23, 32'h0, 1));
    vecs.push_back(mkv(enc_i('h13, 24, 3, 2, -1),    32'h148, 32'h14C, 0, 0, 24, 32'h1, 1));
    vecs.push_back(mkv(enc_u(15, 'h12345),           32'h14C, 32'h150, 0, 0, 15, 32'h12345000, 1));
    vecs.push_back(mkv(enc_j(17, 'h20),              32'h300, 32'h320, 0, 0, 17, 32'h304, 1));
    vecs.push_back(mkv(enc_j(0, -8),                 32'h400, 32'h3F8, 0, 0, 0,  32'h0, 1));
    vecs.push_back(mkv(enc_i('h13, 0, 0, 0, 5),      32'h404, 32'h408, 0, 0, 0,  32'h0, 1));
    vecs.push_back(mkv(enc_b(0, 2, 2, -4),           32'h500, 32'h4FC, 0, 0, 0,  32'h0, 0));
    vecs.push_back(mkv(enc_b(1, 2, 2, -4),           32'h500, 32'h504, 0, 0, 0,  32'h0, 0));
    vecs.push_back(mkv(enc_b(5, 1, 2, 8),            32'h600, 32'h604, 0, 0, 0,  32'h0, 0));
    vecs.push_back(mkv(enc_b(7, 1, 2, 8),            32'h600, 32'h608, 0, 0, 0,  32'h0, 0));
    vecs.push_back(mkv(32'h0000007F,                 32'h700, 32'h704, 1, 1, 0,  32'h0, 0));
    vecs.push_back(mkv(enc_b(2, 1, 2, 16),           32'h704, 32'h708, 1, 1, 16, 32'h0, 1));
    vecs.push_back(mkv(enc_r(1, 2, 1, 0, 25),        32'h708, 32'h70C, 1, 1, 25, 32'h0, 1));

    foreach (vecs[i]) begin
      exec(vecs[i].ins, vecs[i].pc, -1, 32'h0);
      check($sformatf("v%0d_latency", i), 32'(r_lat), 32'd2);
      check($sformatf("v%0d_next_pc", i), r_np, vecs[i].np);
      check($sformatf("v%0d_trap", i), {30'b0, r_trap, 1'b0} | {30'b0, r_cause},
            {30'b0, vecs[i].trp, 1'b0} | {30'b0, vecs[i].cause});
      check($sformatf("v%0d_no_bus", i), 32'(r_req), 32'd0);
      if (vecs[i].chk) begin
        read_reg(vecs[i].rd, rv);
        check($sformatf("v%0d_x%0d", i, vecs[i].rd), rv, vecs[i].val);
      end
    end

    // LB x3,1(x0): ack after 3 wait cycles.
    exec(enc_i('h03, 3, 0, 0, 1), 32'h1000, 3, 32'h00000080);
    check("lb_addr", r_addr, 32'h1);
    check("lb_size_we", {28'b0, r_we, r_size}, 32'h0);
    check("lb_req_cycles", 32'(r_req), 32'd4);
    check("lb_latency", 32'(r_lat), 32'd6);
    check("lb_next_pc", r_np, 32'h1004);
    read_reg(3, rv);
    check("lb_x3", rv, 32'hFFFFFF80);
    exec(enc_i('h03, 3, 4, 0, 1), 32'h1004, 3, 32'h00000080);
    check("lbu_size", {29'b0, r_size}, 32'h4);
    read_reg(3, rv);
    check("lbu_x3", rv, 32'h00000080);
    exec(enc_i('h03, 3, 1, 0, 2), 32'h1008, 0, 32'h00018001);
    check("lh_latency", 32'(r_lat), 32'd3);
    read_reg(3, rv);
    check("lh_x3", rv, 32'hFFFF8001);

    // Aligned stores.
    exec(enc_s(1, 0, 1, 6), 32'h1100, 0, 32'h0);
    check("sh_addr", r_addr, 32'h6);
    check("sh_we_size", {28'b0, r_we, r_size}, 32'h9);
    check("sh_wdata", r_wdata, 32'hFFFFFFFB);
    check("sh_trap", 32'(r_trap), 32'h0);
    exec(enc_s(0, 2, 1, -1), 32'h1104, 0, 32'h0);
    check("sb_addr", r_addr, 32'h2);

    // Misaligned accesses trap without touching the bus.
    exec(enc_s(2, 0, 2, 'h102), 32'h1200, 0, 32'h0);
    check("sw_mis_cause", {29'b0, r_trap, r_cause}, 32'h6);
    check("sw_mis_no_req", 32'(r_req), 32'd0);
    check("sw_mis_next_pc", r_np, 32'h1204);
    exec(enc_s(1, 0, 2, 1), 32'h1204, 0, 32'h0);
    check("sh_mis_cause", {29'b0, r_trap, r_cause}, 32'h6);
    exec(enc_i('h03, 3, 1, 0, 3), 32'h1208, 0, 32'h0);
    check("lh_mis_cause", {29'b0, r_trap, r_cause}, 32'h6);
    read_reg(3, rv);
    check("lh_mis_x3_kept", rv, 32'hFFFF8001);

    // Bus timeout, then ack on the last allowed cycle.
    exec(enc_i('h13, 18, 0, 0, 7), 32'h1300, -1, 32'h0);
    exec(enc_i('h03, 18, 2, 0, 0), 32'h1304, -1, 32'h0);
    check("to_req_cycles", 32'(r_req), 32'd16);
    check("to_cause", {29'b0, r_trap, r_cause}, 32'h7);
    check("to_latency", 32'(r_lat), 32'd18);
    check("to_next_pc", r_np, 32'h1308);
    read_reg(18, rv);
    check("to_x18_kept", rv, 32'h7);
    exec(enc_i('h03, 18, 2, 0, 0), 32'h1308, 15, 32'hCAFEF00D);
    check("ack16_req_cycles", 32'(r_req), 32'd16);
    check("ack16_trap", {29'b0, r_trap, r_cause}, 32'h0);
    check("ack16_latency", 32'(r_lat), 32'd18);
    read_reg(18, rv);
    check("ack16_x18", rv, 32'hCAFEF00D);

    // instr_valid pulses while busy are ignored.
    pulse_busy = 1'b1;
    pulse_ins  = enc_i('h13, 19, 0, 0, 'h66);
    exec(enc_i('h13, 19, 0, 0, 'h55), 32'h1400, -1, 32'h0);
    pulse_busy = 1'b0;
    check("busy_latency", 32'(r_lat), 32'd2);
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("busy_no_extra_done", 32'(ndone), 32'd0);
    read_reg(19, rv);
    check("busy_x19", rv, 32'h55);

    // Reset while in MEM.
    @(negedge clk);
    instr_valid = 1'b1;
    instruction = enc_i('h03, 1, 2, 0, 0);
    pc          = 32'h1500;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("mem_req_before_reset", 32'(bus_req), 32'h1);
    reset = 1'b1;
    #1;
    check("reset_drops_req", 32'(bus_req), 32'h0);
    check("reset_ready", 32'(instr_ready), 32'h1);
    check("reset_no_done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    read_reg(1, rv);
    check("reset_clears_x1", rv, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
